// File: rtl/matrix_line_buffer.sv
// -----------------------------------------------------------------------------
// matrix_line_buffer
//
// Three-row line buffer feeding a 3x3 morphological window stage. For every
// accepted raster pixel (y, c) it emits one beat holding the vertically
// aligned column {(y-2,c), (y-1,c), (y,c)} on dout1/dout2/dout3. Beats are
// suppressed for rows 0 and 1 of each frame, where the line memories do not
// yet hold two rows of the current frame.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   valid_in   din carries a pixel this cycle
//   sof        start of frame, qualified by valid_in (pixel is row 0, col 0)
//   din        incoming pixel, raster order
//   valid_out  one-cycle strobe, dout1..3 hold a valid beat
//   dout1      pixel from row y-2 (window top)
//   dout2      pixel from row y-1 (window middle)
//   dout3      pixel from row y   (window bottom, the current input)
//   eof_out    high with valid_out on the beat of the last pixel of a frame
//
// Handshake: valid-only, no backpressure. A pixel is accepted on every rising
// edge where valid_in=1; gaps of any length are allowed. valid_out/eof_out
// are registered strobes appearing exactly one cycle after the accepting edge;
// dout1..3 hold their last beat whenever no pixel is accepted.
// -----------------------------------------------------------------------------
module matrix_line_buffer #(
  parameter int PIC_WIDTH  = 250,
  parameter int PIC_HEIGHT = 250,
  parameter int WIDTH      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             sof,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             eof_out
);

  localparam int CW = 10;
  localparam int AW = $clog2(PIC_WIDTH);
  localparam logic [CW-1:0] LAST_COL = CW'(PIC_WIDTH - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(PIC_HEIGHT - 1);
  localparam logic [CW-1:0] FIRST_OUT_ROW = CW'(2);

  // Position counters: where the next accepted pixel lands.
  logic [CW-1:0] col_cnt;
  logic [CW-1:0] row_cnt;

  // Position of the pixel on din this cycle (sof overrides the counters).
  logic [CW-1:0] cur_col;
  logic [CW-1:0] cur_row;
  logic [CW-1:0] nxt_col;
  logic [CW-1:0] nxt_row;
  logic          last_col;
  logic          last_row;
  logic          out_row;

  // line_a holds row y-1, line_b holds row y-2. Not reset: contents from a
  // previous or abandoned frame are never emitted because rows 0-1 are gated.
  logic [WIDTH-1:0] line_a [PIC_WIDTH];
  logic [WIDTH-1:0] line_b [PIC_WIDTH];

  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] a_rd;
  logic [WIDTH-1:0] b_rd;

  // ---------------------------------------------------------------------------
  // Current position and next-position arithmetic
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_col  = col_cnt;
    cur_row  = row_cnt;
    if (sof) begin
      cur_col = '0;
      cur_row = '0;
    end

    last_col = (cur_col == LAST_COL);
    last_row = (cur_row == LAST_ROW);
    out_row  = (cur_row >= FIRST_OUT_ROW);

    nxt_col  = cur_col + CW'(1);
    nxt_row  = cur_row;
    if (last_col) begin
      nxt_col = '0;
      nxt_row = last_row ? '0 : cur_row + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Line memories: asynchronous read-first, write on accepted pixel. The
  // column shifts down one row: old line_a moves to line_b, din into line_a.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_addr = cur_col[AW-1:0];
    a_rd    = line_a[rd_addr];
    b_rd    = line_b[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (valid_in) begin
      line_b[rd_addr] <= a_rd;
      line_a[rd_addr] <= din;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      dout1     <= '0;
      dout2     <= '0;
      dout3     <= '0;
      valid_out <= 1'b0;
      eof_out   <= 1'b0;
    end else begin
      // Strobes default low; only an accepted pixel can raise them.
      valid_out <= 1'b0;
      eof_out   <= 1'b0;
      if (valid_in) begin
        col_cnt   <= nxt_col;
        row_cnt   <= nxt_row;
        dout1     <= b_rd;
        dout2     <= a_rd;
        dout3     <= din;
        valid_out <= out_row;
        // With sof the position is (0,0), so a coincident last pixel never
        // raises eof_out.
        eof_out   <= last_col && last_row;
      end
    end
  end

endmodule

// File: doc/matrix_line_buffer.md
# matrix_line_buffer

Three-row line buffer that turns a raster pixel stream into three vertically aligned row streams for the 3x3 morphological window stage (erosion/dilation) directly downstream. Each accepted pixel at column c of row y produces one output beat carrying pixel (y-2, c), (y-1, c) and (y, c) on `dout1`, `dout2` and `dout3`. The window stage shifts these beats horizontally to form its 3x3 neighbourhood.

## Interface
Parameters:
- `PIC_WIDTH`, 250: pixels per row; legal range 3..1023.
- `PIC_HEIGHT`, 250: rows per frame; legal range 3..1023.
- `WIDTH`, 24: pixel data width in bits.

Ports:
- `clk`  input  1  single clock; all logic is on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `valid_in`  input  1  `din` holds a pixel this cycle.
- `sof`  input  1  start of frame; qualified by `valid_in`; marks the current pixel as row 0, column 0.
- `din`  input  WIDTH  incoming pixel, raster order.
- `valid_out`  output  1  one-cycle strobe; `dout1..3` hold a valid beat.
- `dout1`  output  WIDTH  pixel from row y-2 (top row of the window).
- `dout2`  output  WIDTH  pixel from row y-1 (middle row).
- `dout3`  output  WIDTH  pixel from row y (bottom row, the current input).
- `eof_out`  output  1  high together with `valid_out` on the beat for the last pixel of the frame.

## Operation
- Storage is two line memories, `line_a` (row y-1) and `line_b` (row y-2), each PIC_WIDTH x WIDTH. Memories are not cleared by reset.
- Counters:
  - `col_cnt` runs 0..PIC_WIDTH-1.
  - `row_cnt` runs 0..PIC_HEIGHT-1.
  - Both are sized to 10 bits.
- On each cycle with `valid_in`=1 at column c:
  - Read `line_a[c]` and `line_b[c]`. Reads return the values held before this cycle's writes (read-first).
  - Register `dout3`<=`din`, `dout2`<=`line_a[c]`, `dout1`<=`line_b[c]`.
  - Write `line_b[c]`<=old `line_a[c]` and `line_a[c]`<=`din`.
  - Advance the counters:
    - If c=PIC_WIDTH-1: `col_cnt`<=0 and `row_cnt` increments.
    - If c=PIC_WIDTH-1 and the row is PIC_HEIGHT-1: `row_cnt`<=0 (frame wrap).
- `sof`=1 with `valid_in`=1: the pixel is treated as column 0, row 0, whatever the counter values. Counters then become col 1, row 0. A partial frame in progress is abandoned.
- `sof` with `valid_in`=0 is ignored.
- Output gating:
  - `valid_out` is registered: it equals `valid_in` from the previous cycle AND the row of that pixel being >=2.
  - Rows 0 and 1 therefore produce no output beats.
  - Each frame yields (PIC_HEIGHT-2) x PIC_WIDTH beats.
- `eof_out` is registered: `valid_in` AND col=PIC_WIDTH-1 AND row=PIC_HEIGHT-1.
- `valid_in`=0 (stall):
  - Counters, memories and `dout1..3` hold.
  - `valid_out`=0 and `eof_out`=0 on the following cycle.
- Reset values: `dout1`=`dout2`=`dout3`=0, `valid_out`=0, `eof_out`=0, `col_cnt`=0, `row_cnt`=0.

## Timing
- Latency is 1 cycle from the `valid_in` edge to the `valid_out` edge.
- No backpressure: one beat can be accepted every cycle, with arbitrary gaps.
- `dout1..3` change only on cycles following an accepted pixel. During stalls they keep the last beat.
- Reset mid-operation (asynchronous):
  - Outputs and counters clear immediately.
  - The next accepted pixel is row 0, col 0.
  - Stale memory contents are never output, because rows 0-1 are gated.
- Simultaneous `sof` and last-pixel-of-frame: `sof` wins. No `eof_out` is produced for that pixel; it is emitted as row 0, col 0.
- First valid beat of a frame: the cycle after pixel (2,0) is accepted.

## Test plan
- Reset: hold `rst`=1 with random `din`/`valid_in` -> all outputs 0. Release, then send 1 pixel -> `valid_out` stays 0.
- Basic frame, PIC_WIDTH=4, PIC_HEIGHT=4, pixel=row*16+col, continuous valid:
  - Exactly 8 beats.
  - Beat for (2,1) gives `dout1`=0x01, `dout2`=0x11, `dout3`=0x21.
  - Beat for (3,3) gives 0x13/0x23/0x33 with `eof_out`=1.
- Stalls: same frame with `valid_in` toggling 1,0,0,1 pseudo-randomly -> identical beat sequence. `valid_out` pulses only after accepted pixels, and `dout` holds during gaps.
- Back-to-back frames with no gap:
  - Second frame pixels = 0x80+row*16+col.
  - No beats during its rows 0-1.
  - First beat gives 0x80/0x90/0xA0.
- `sof` mid-frame: assert `sof` at pixel (2,2) of frame 1 -> that pixel is treated as (0,0). No output for the next 2xPIC_WIDTH accepted pixels; then normal beats.
- Reset at (3,1), then a new frame -> no beats until row 2 of the new frame. Values match the new frame only.
